// File: rtl/calc1_req_sched.sv
// calc1 request scheduler: two-beat command capture from four requesters,
// independent round-robin dispatch to adder/shifter, fixed-latency result return.
module calc1_req_sched #(
    parameter int ADD_LAT = 3,
    parameter int SHF_LAT = 3
) (
    input  logic         c_clk,
    input  logic         reset,
    input  logic [15:0]  req_cmd_in,
    input  logic [127:0] req_data_in,
    output logic         alu1_vld,
    output logic [3:0]   alu1_cmd,
    output logic [1:0]   alu1_req_id,
    output logic [31:0]  alu1_data1,
    output logic [31:0]  alu1_data2,
    output logic         alu2_vld,
    output logic [3:0]   alu2_cmd,
    output logic [1:0]   alu2_req_id,
    output logic [31:0]  alu2_data1,
    output logic [31:0]  alu2_data2,
    input  logic [31:0]  alu1_result,
    input  logic         alu1_ovfl,
    input  logic [31:0]  alu2_result,
    input  logic         alu2_ovfl,
    output logic [7:0]   out_resp,
    output logic [127:0] out_data,
    output logic [3:0]   req_busy,
    output logic [3:0]   proto_err
);

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;

    function automatic logic is_add(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2);
    endfunction

    function automatic logic is_shf(input logic [3:0] c);
        return (c == 4'd5) || (c == 4'd6);
    endfunction

    // Returns {found, index}; scans from ptr upward with wrap, lowest offset wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [3:0]        cmd_in  [NREQ];
    logic [DATA_W-1:0] data_in [NREQ];
    logic [3:0]        cmd_r   [NREQ];
    logic [DATA_W-1:0] op1_r   [NREQ];
    logic [DATA_W-1:0] op2_r   [NREQ];
    logic [3:0]        busy, beat2, pend_add, pend_shf;
    logic [1:0]        ptr_add, ptr_shf;

    logic [ADD_LAT:1]  add_vld_p;
    logic [1:0]        add_id_p [1:ADD_LAT];
    logic [SHF_LAT:1]  shf_vld_p;
    logic [1:0]        shf_id_p [1:SHF_LAT];

    logic [3:0]        cand_add, cand_shf, win_add_mask, win_shf_mask;
    logic [2:0]        pick_add, pick_shf;
    logic [DATA_W-1:0] add_op2, shf_op2;

    assign req_busy = busy;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cmd_in[i]  = req_cmd_in[4*i +: 4];
            data_in[i] = req_data_in[DATA_W*i +: DATA_W];
        end
    end

    // A requester in its second beat competes immediately; its operand 2 is still on the bus.
    always_comb begin
        cand_add     = '0;
        cand_shf     = '0;
        win_add_mask = '0;
        win_shf_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_add[i] = pend_add[i] | (beat2[i] & is_add(cmd_r[i]));
            cand_shf[i] = pend_shf[i] | (beat2[i] & is_shf(cmd_r[i]));
        end
        pick_add = rr_pick(cand_add, ptr_add);
        pick_shf = rr_pick(cand_shf, ptr_shf);
        if (pick_add[2]) win_add_mask[pick_add[1:0]] = 1'b1;
        if (pick_shf[2]) win_shf_mask[pick_shf[1:0]] = 1'b1;
        add_op2 = beat2[pick_add[1:0]] ? data_in[pick_add[1:0]] : op2_r[pick_add[1:0]];
        shf_op2 = beat2[pick_shf[1:0]] ? data_in[pick_shf[1:0]] : op2_r[pick_shf[1:0]];
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                cmd_r[i] <= '0;
                op1_r[i] <= '0;
                op2_r[i] <= '0;
            end
            busy        <= '0;
            beat2       <= '0;
            pend_add    <= '0;
            pend_shf    <= '0;
            proto_err   <= '0;
            ptr_add     <= '0;
            ptr_shf     <= '0;
            alu1_vld    <= 1'b0;
            alu1_cmd    <= '0;
            alu1_req_id <= '0;
            alu1_data1  <= '0;
            alu1_data2  <= '0;
            alu2_vld    <= 1'b0;
            alu2_cmd    <= '0;
            alu2_req_id <= '0;
            alu2_data1  <= '0;
            alu2_data2  <= '0;
            add_vld_p   <= '0;
            shf_vld_p   <= '0;
            for (int s = 1; s <= ADD_LAT; s++) add_id_p[s] <= '0;
            for (int s = 1; s <= SHF_LAT; s++) shf_id_p[s] <= '0;
            out_resp    <= '0;
            out_data    <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            alu1_vld <= 1'b0;
            alu2_vld <= 1'b0;

            // Capture and classification
            for (int i = 0; i < NREQ; i++) begin
                if (!busy[i]) begin
                    if (cmd_in[i] != 4'd0) begin
                        cmd_r[i] <= cmd_in[i];
                        op1_r[i] <= data_in[i];
                        busy[i]  <= 1'b1;
                        beat2[i] <= 1'b1;
                    end
                end else if (beat2[i]) begin
                    op2_r[i] <= data_in[i];
                    beat2[i] <= 1'b0;
                    if (!is_add(cmd_r[i]) && !is_shf(cmd_r[i])) begin
                        out_resp[2*i +: 2] <= 2'b10;
                        busy[i]            <= 1'b0;
                    end
                end else if (cmd_in[i] != 4'd0) begin
                    proto_err[i] <= 1'b1;
                end
            end
            pend_add <= cand_add & ~win_add_mask;
            pend_shf <= cand_shf & ~win_shf_mask;

            // Dispatch stage
            if (pick_add[2]) begin
                alu1_vld    <= 1'b1;
                alu1_cmd    <= cmd_r[pick_add[1:0]];
                alu1_req_id <= pick_add[1:0];
                alu1_data1  <= op1_r[pick_add[1:0]];
                alu1_data2  <= add_op2;
                ptr_add     <= pick_add[1:0] + 2'd1;
            end
            if (pick_shf[2]) begin
                alu2_vld    <= 1'b1;
                alu2_cmd    <= cmd_r[pick_shf[1:0]];
                alu2_req_id <= pick_shf[1:0];
                alu2_data1  <= op1_r[pick_shf[1:0]];
                alu2_data2  <= shf_op2;
                ptr_shf     <= pick_shf[1:0] + 2'd1;
            end

            // Tag pipes: stage s holds the dispatch from s cycles earlier
            for (int s = ADD_LAT; s > 1; s--) begin
                add_vld_p[s] <= add_vld_p[s-1];
                add_id_p[s]  <= add_id_p[s-1];
            end
            add_vld_p[1] <= alu1_vld;
            add_id_p[1]  <= alu1_req_id;
            for (int s = SHF_LAT; s > 1; s--) begin
                shf_vld_p[s] <= shf_vld_p[s-1];
                shf_id_p[s]  <= shf_id_p[s-1];
            end
            shf_vld_p[1] <= alu2_vld;
            shf_id_p[1]  <= alu2_req_id;

            // Result return stage
            for (int i = 0; i < NREQ; i++) begin
                if (add_vld_p[ADD_LAT] && add_id_p[ADD_LAT] == 2'(i)) begin
                    out_resp[2*i +: 2]           <= alu1_ovfl ? 2'b10 : 2'b01;
                    out_data[DATA_W*i +: DATA_W] <= alu1_result;
                    busy[i]                      <= 1'b0;
                end
                if (shf_vld_p[SHF_LAT] && shf_id_p[SHF_LAT] == 2'(i)) begin
                    out_resp[2*i +: 2]           <= alu2_ovfl ? 2'b10 : 2'b01;
                    out_data[DATA_W*i +: DATA_W] <= alu2_result;
                    busy[i]                      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc1_req_sched.sv
// Directed bench for calc1_req_sched with behavioural adder/shifter models
// returning results LAT cycles after each dispatch.
module tb_calc1_req_sched;

    localparam int LAT = 3;

    logic         c_clk = 1'b0;
    logic         reset;
    logic [15:0]  req_cmd_in;
    logic [127:0] req_data_in;
    logic         alu1_vld, alu2_vld;
    logic [3:0]   alu1_cmd, alu2_cmd;
    logic [1:0]   alu1_req_id, alu2_req_id;
    logic [31:0]  alu1_data1, alu1_data2, alu2_data1, alu2_data2;
    logic [31:0]  alu1_result, alu2_result;
    logic         alu1_ovfl, alu2_ovfl;
    logic [7:0]   out_resp;
    logic [127:0] out_data;
    logic [3:0]   req_busy, proto_err;

    int checks = 0;
    int errors = 0;

    calc1_req_sched #(.ADD_LAT(LAT), .SHF_LAT(LAT)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .alu1_vld(alu1_vld), .alu1_cmd(alu1_cmd), .alu1_req_id(alu1_req_id),
        .alu1_data1(alu1_data1), .alu1_data2(alu1_data2),
        .alu2_vld(alu2_vld), .alu2_cmd(alu2_cmd), .alu2_req_id(alu2_req_id),
        .alu2_data1(alu2_data1), .alu2_data2(alu2_data2),
        .alu1_result(alu1_result), .alu1_ovfl(alu1_ovfl),
        .alu2_result(alu2_result), .alu2_ovfl(alu2_ovfl),
        .out_resp(out_resp), .out_data(out_data),
        .req_busy(req_busy), .proto_err(proto_err)
    );

    always #5 c_clk = ~c_clk;

    function automatic logic [32:0] add_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        if (c == 4'd2) begin
            r  = a - b;
            ov = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r  = a + b;
            ov = (a[31] == b[31]) && (r[31] != a[31]);
        end
        return {ov, r};
    endfunction

    function automatic logic [32:0] shf_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        return {1'b0, (c == 4'd6) ? (a >> b[4:0]) : (a << b[4:0])};
    endfunction

    // ALU models: unflagged cycles present junk with ovfl set, which must be ignored.
    bit        m1_vld [0:LAT];
    bit [32:0] m1_res [0:LAT];
    bit        m2_vld [0:LAT];
    bit [32:0] m2_res [0:LAT];

    always @(negedge c_clk) begin
        for (int k = LAT; k > 0; k--) begin
            m1_vld[k] = m1_vld[k-1];
            m1_res[k] = m1_res[k-1];
            m2_vld[k] = m2_vld[k-1];
            m2_res[k] = m2_res[k-1];
        end
        m1_vld[0] = alu1_vld;
        m1_res[0] = add_model(alu1_cmd, alu1_data1, alu1_data2);
        m2_vld[0] = alu2_vld;
        m2_res[0] = shf_model(alu2_cmd, alu2_data1, alu2_data2);
        if (m1_vld[LAT]) {alu1_ovfl, alu1_result} = m1_res[LAT];
        else             {alu1_ovfl, alu1_result} = {1'b1, 32'hDEADBEEF};
        if (m2_vld[LAT]) {alu2_ovfl, alu2_result} = m2_res[LAT];
        else             {alu2_ovfl, alu2_result} = {1'b1, 32'hBADC0FFE};
    end

    task automatic step(input int n);
        repeat (n) @(posedge c_clk);
        #1;
    endtask

    task automatic put(input int i, input logic [3:0] cmd, input logic [31:0] d);
        req_cmd_in[4*i +: 4]   = cmd;
        req_data_in[32*i +: 32] = d;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        step(2);
        check("rst_resp", out_resp, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", req_busy, 0);
        check("rst_perr", proto_err, 0);
        check("rst_vld1", alu1_vld, 0);
        check("rst_vld2", alu2_vld, 0);
        reset = 1'b1;
        step(1);

        // Round robin: four subtracts at once
        put(0, 2, 10); put(1, 2, 20); put(2, 2, 30); put(3, 2, 40);
        step(1);
        put(0, 0, 1); put(1, 0, 2); put(2, 0, 3); put(3, 0, 4);
        check("rr_busy", req_busy, 4'hF);
        step(1);
        check("rr_v0", alu1_vld, 1);
        check("rr_id0", alu1_req_id, 0);
        check("rr_cmd0", alu1_cmd, 2);
        check("rr_d1_0", alu1_data1, 10);
        check("rr_d2_0", alu1_data2, 1);
        check("rr_v2_idle", alu2_vld, 0);
        step(1);
        check("rr_id1", alu1_req_id, 1);
        check("rr_d1_1", alu1_data1, 20);
        check("rr_d2_1", alu1_data2, 2);
        step(1);
        check("rr_id2", alu1_req_id, 2);
        check("rr_d2_2", alu1_data2, 3);
        step(1);
        check("rr_v3", alu1_vld, 1);
        check("rr_id3", alu1_req_id, 3);
        check("rr_d2_3", alu1_data2, 4);
        step(1);
        check("rr_resp0", out_resp, 8'h01);
        check("rr_data0", out_data, {96'd0, 32'd9});
        check("rr_v_off", alu1_vld, 0);
        step(1);
        check("rr_resp1", out_resp, 8'h04);
        check("rr_data1", out_data, {64'd0, 32'd18, 32'd0});
        step(1);
        check("rr_resp2", out_resp, 8'h10);
        check("rr_data2", out_data, {32'd0, 32'd27, 64'd0});
        step(1);
        check("rr_resp3", out_resp, 8'h40);
        check("rr_data3", out_data, {32'd36, 96'd0});
        check("rr_busy_end", req_busy, 0);

        // Single add
        put(0, 1, 5);
        step(1);
        put(0, 0, 3);
        step(1);
        check("add_vld", alu1_vld, 1);
        check("add_id", alu1_req_id, 0);
        check("add_d1", alu1_data1, 5);
        check("add_d2", alu1_data2, 3);
        step(3);
        check("add_early", out_resp, 0);
        check("add_busy", req_busy, 4'b0001);
        step(1);
        check("add_resp", out_resp, 8'h01);
        check("add_data", out_data, {96'd0, 32'd8});
        check("add_busy_clr", req_busy, 0);

        // Follow-up: req1 reissues in its response cycle alongside req3; pointer sits at 1
        put(0, 1, 100); put(2, 1, 300);
        step(1);
        put(0, 0, 1); put(2, 0, 3);
        check("fu_busy", req_busy, 4'b0101);
        step(1);
        check("fu_id_a", alu1_req_id, 2);
        check("fu_d1_a", alu1_data1, 300);
        step(1);
        check("fu_id_b", alu1_req_id, 0);
        check("fu_d1_b", alu1_data1, 100);
        step(3);
        check("fu_resp_a", out_resp, 8'h10);
        check("fu_data_a", out_data, {32'd0, 32'd303, 64'd0});
        step(1);
        check("fu_resp_b", out_resp, 8'h01);
        check("fu_data_b", out_data, {96'd0, 32'd101});

        // Parallel paths
        put(1, 5, 1); put(2, 1, 7);
        step(1);
        put(1, 0, 4); put(2, 0, 8);
        step(1);
        check("par_v1", alu1_vld, 1);
        check("par_id1", alu1_req_id, 2);
        check("par_v2", alu2_vld, 1);
        check("par_id2", alu2_req_id, 1);
        check("par_cmd2", alu2_cmd, 5);
        check("par_d1_2", alu2_data1, 1);
        check("par_d2_2", alu2_data2, 4);
        step(4);
        check("par_resp", out_resp, 8'h14);
        check("par_data", out_data, {32'd0, 32'd15, 32'h10, 32'd0});

        // Invalid command on req4, overflowing add on req1
        put(3, 3, 32'hAAAA); put(0, 1, 32'h7FFFFFFF);
        step(1);
        put(3, 0, 32'h5555); put(0, 0, 1);
        step(1);
        check("inv_resp", out_resp, 8'h80);
        check("inv_data", out_data, 0);
        check("inv_busy", req_busy, 4'b0001);
        check("inv_v1", alu1_vld, 1);
        check("inv_id1", alu1_req_id, 0);
        check("inv_v2", alu2_vld, 0);
        step(1);
        check("inv_nodisp1", alu1_vld, 0);
        check("inv_nodisp2", alu2_vld, 0);
        step(3);
        check("ovf_resp", out_resp, 8'h02);
        check("ovf_data", out_data, {96'd0, 32'h80000000});

        // Protocol violation while busy
        put(0, 1, 6);
        step(1);
        put(0, 0, 7);
        step(1);
        check("pe_vld", alu1_vld, 1);
        check("pe_d1", alu1_data1, 6);
        check("pe_d2", alu1_data2, 7);
        step(1);
        put(0, 6, 32'hFFFF);
        step(1);
        put(0, 0, 0);
        check("pe_flag", proto_err, 4'b0001);
        check("pe_busy", req_busy, 4'b0001);
        step(1);
        check("pe_no_shf", alu2_vld, 0);
        check("pe_no_add", alu1_vld, 0);
        step(1);
        check("pe_resp", out_resp, 8'h01);
        check("pe_data", out_data, {96'd0, 32'd13});
        check("pe_sticky", proto_err, 4'b0001);
        check("pe_busy_clr", req_busy, 0);

        // Reset with operations in flight on both paths
        put(1, 1, 1); put(2, 5, 2);
        step(1);
        put(1, 0, 1); put(2, 0, 3);
        step(1);
        check("mr_v1", alu1_vld, 1);
        check("mr_id1", alu1_req_id, 1);
        check("mr_v2", alu2_vld, 1);
        check("mr_id2", alu2_req_id, 2);
        step(1);
        reset = 1'b0;
        step(1);
        check("mr_busy", req_busy, 0);
        check("mr_perr", proto_err, 0);
        check("mr_resp", out_resp, 0);
        reset = 1'b1;
        step(2);
        check("mr_late_resp", out_resp, 0);
        check("mr_late_data", out_data, 0);
        check("mr_late_busy", req_busy, 0);
        step(1);
        check("mr_late_resp2", out_resp, 0);

        // Both pointers must be back at requester 0
        put(0, 1, 11); put(2, 2, 33); put(1, 5, 3); put(3, 6, 32'h80);
        step(1);
        put(0, 0, 1); put(2, 0, 3); put(1, 0, 3); put(3, 0, 4);
        step(1);
        check("pr_add_id_a", alu1_req_id, 0);
        check("pr_add_d1_a", alu1_data1, 11);
        check("pr_shf_id_a", alu2_req_id, 1);
        check("pr_shf_cmd_a", alu2_cmd, 5);
        step(1);
        check("pr_add_id_b", alu1_req_id, 2);
        check("pr_add_d1_b", alu1_data1, 33);
        check("pr_shf_id_b", alu2_req_id, 3);
        check("pr_shf_cmd_b", alu2_cmd, 6);
        step(3);
        check("pr_resp_a", out_resp, 8'h05);
        check("pr_data_a", out_data, {64'd0, 32'd24, 32'd12});
        step(1);
        check("pr_resp_b", out_resp, 8'h50);
        check("pr_data_b", out_data, {32'd8, 32'd30, 64'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
